// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state and trap
// encodings, instruction classes, opcode/funct codes, ALU op codes and
// datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM    = 2'b10,
    CAUSE_DMEM    = 2'b11
  } trap_cause_e;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_ILLEGAL
  } instr_class_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] INSTR_RTYPE = 6'h00;
  localparam logic [5:0] INSTR_J     = 6'h02;
  localparam logic [5:0] INSTR_JAL   = 6'h03;
  localparam logic [5:0] INSTR_BEQ   = 6'h04;
  localparam logic [5:0] INSTR_BNE   = 6'h05;
  localparam logic [5:0] INSTR_ADDI  = 6'h08;
  localparam logic [5:0] INSTR_ADDIU = 6'h09;
  localparam logic [5:0] INSTR_SLTI  = 6'h0A;
  localparam logic [5:0] INSTR_SLTIU = 6'h0B;
  localparam logic [5:0] INSTR_ANDI  = 6'h0C;
  localparam logic [5:0] INSTR_ORI   = 6'h0D;
  localparam logic [5:0] INSTR_XORI  = 6'h0E;
  localparam logic [5:0] INSTR_LUI   = 6'h0F;
  localparam logic [5:0] INSTR_LW    = 6'h23;
  localparam logic [5:0] INSTR_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // ALU op codes; the largest needs 5 bits
  localparam int unsigned ALUOp_ADD  = 0;
  localparam int unsigned ALUOp_ADDU = 1;
  localparam int unsigned ALUOp_SUB  = 2;
  localparam int unsigned ALUOp_SUBU = 3;
  localparam int unsigned ALUOp_AND  = 4;
  localparam int unsigned ALUOp_OR   = 5;
  localparam int unsigned ALUOp_XOR  = 6;
  localparam int unsigned ALUOp_NOR  = 7;
  localparam int unsigned ALUOp_SLT  = 8;
  localparam int unsigned ALUOp_SLTU = 9;
  localparam int unsigned ALUOp_SLL  = 10;
  localparam int unsigned ALUOp_SRL  = 11;
  localparam int unsigned ALUOp_SRA  = 12;
  localparam int unsigned ALUOp_SLLV = 13;
  localparam int unsigned ALUOp_SRLV = 14;
  localparam int unsigned ALUOp_SRAV = 15;
  localparam int unsigned ALUOp_LUI  = 16;
  localparam int unsigned ALUOp_EQL  = 17;
  localparam int unsigned ALUOp_BNE  = 18;

  localparam logic       SEL_ALUSRC_REG = 1'b0;
  localparam logic       SEL_ALUSRC_IMM = 1'b1;
  localparam logic [1:0] SEL_REGDST_RT  = 2'd0;
  localparam logic [1:0] SEL_REGDST_RD  = 2'd1;
  localparam logic [1:0] SEL_REGDST_RA  = 2'd2;
  localparam logic [1:0] SEL_WB_ALUOUT  = 2'd0;
  localparam logic [1:0] SEL_WB_DM      = 2'd1;
  localparam logic [1:0] SEL_WB_PC4     = 2'd2;
  localparam logic [1:0] NPC_PC4        = 2'd0;
  localparam logic [1:0] NPC_JMP        = 2'd1;
  localparam logic [1:0] NPC_BRANCH     = 2'd2;
  localparam logic       EXT_MODE_UNSIGNED = 1'b0;
  localparam logic       EXT_MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-unit <-> datapath/memory signal bundle.
// master: the control unit (drives requests, enables, selects, status).
// slave : datapath and memories (drive run, IR fields, branch result, readies).
interface mc_ctrl_if #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned CNT_W   = 32
);
  logic               run;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               branch_taken;
  logic               imem_ready;
  logic               dmem_ready;
  logic               imem_req;
  logic               ir_write;
  logic               dmem_req;
  logic               dmem_we;
  logic               pc_write;
  logic [1:0]         npc_from;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               alu_src1;
  logic               alu_src2;
  logic [ALUOP_W-1:0] alu_op;
  logic               imm_ext;
  logic [2:0]         state_o;
  logic               trap;
  logic [1:0]         trap_cause;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  run, opcode, funct, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, dmem_we, pc_write, npc_from,
           reg_write, reg_dst, mem_to_reg, alu_src1, alu_src2, alu_op,
           imm_ext, state_o, trap, trap_cause, retired
  );

  modport slave (
    output run, opcode, funct, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, dmem_we, pc_write, npc_from,
           reg_write, reg_dst, mem_to_reg, alu_src1, alu_src2, alu_op,
           imm_ext, state_o, trap, trap_cause, retired
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> class, ALU op,
// ALU operand selects, immediate extension mode and legality.
// Ports: opcode, funct in; cls, alu_op, alu_src1, alu_src2, imm_ext, legal out.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 5
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output instr_class_e       cls,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src1,
  output logic               alu_src2,
  output logic               imm_ext,
  output logic               legal
);

  int unsigned op_c;

  always_comb begin
    cls      = CLS_ILLEGAL;
    op_c     = ALUOp_ADDU;
    alu_src1 = SEL_ALUSRC_REG;
    alu_src2 = SEL_ALUSRC_REG;
    imm_ext  = EXT_MODE_UNSIGNED;
    case (opcode)
      INSTR_RTYPE: begin
        cls = CLS_ALU_R;
        case (funct)
          FUNCT_ADD:  op_c = ALUOp_ADD;
          FUNCT_ADDU: op_c = ALUOp_ADDU;
          FUNCT_SUB:  op_c = ALUOp_SUB;
          FUNCT_SUBU: op_c = ALUOp_SUBU;
          FUNCT_AND:  op_c = ALUOp_AND;
          FUNCT_OR:   op_c = ALUOp_OR;
          FUNCT_XOR:  op_c = ALUOp_XOR;
          FUNCT_NOR:  op_c = ALUOp_NOR;
          FUNCT_SLT:  op_c = ALUOp_SLT;
          FUNCT_SLTU: op_c = ALUOp_SLTU;
          FUNCT_SLLV: op_c = ALUOp_SLLV;
          FUNCT_SRLV: op_c = ALUOp_SRLV;
          FUNCT_SRAV: op_c = ALUOp_SRAV;
          // Constant shifts take shamt through the immediate path on ALU A
          FUNCT_SLL: begin op_c = ALUOp_SLL; alu_src1 = SEL_ALUSRC_IMM; end
          FUNCT_SRL: begin op_c = ALUOp_SRL; alu_src1 = SEL_ALUSRC_IMM; end
          FUNCT_SRA: begin op_c = ALUOp_SRA; alu_src1 = SEL_ALUSRC_IMM; end
          default:   cls = CLS_ILLEGAL;
        endcase
      end
      INSTR_ADDI:  begin cls = CLS_ALU_I; op_c = ALUOp_ADD;  alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_ADDIU: begin cls = CLS_ALU_I; op_c = ALUOp_ADDU; alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_SLTI:  begin cls = CLS_ALU_I; op_c = ALUOp_SLT;  alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_SLTIU: begin cls = CLS_ALU_I; op_c = ALUOp_SLTU; alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_ANDI:  begin cls = CLS_ALU_I; op_c = ALUOp_AND;  alu_src2 = SEL_ALUSRC_IMM; end
      INSTR_ORI:   begin cls = CLS_ALU_I; op_c = ALUOp_OR;   alu_src2 = SEL_ALUSRC_IMM; end
      INSTR_XORI:  begin cls = CLS_ALU_I; op_c = ALUOp_XOR;  alu_src2 = SEL_ALUSRC_IMM; end
      INSTR_LUI:   begin cls = CLS_ALU_I; op_c = ALUOp_LUI;  alu_src2 = SEL_ALUSRC_IMM; end
      INSTR_LW:    begin cls = CLS_LOAD;  op_c = ALUOp_ADDU; alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_SW:    begin cls = CLS_STORE; op_c = ALUOp_ADDU; alu_src2 = SEL_ALUSRC_IMM; imm_ext = EXT_MODE_SIGNED; end
      INSTR_BEQ:   begin cls = CLS_BRANCH; op_c = ALUOp_EQL; end
      INSTR_BNE:   begin cls = CLS_BRANCH; op_c = ALUOp_BNE; end
      INSTR_J:     cls = CLS_JUMP;
      INSTR_JAL:   cls = CLS_JAL;
      default:     cls = CLS_ILLEGAL;
    endcase
  end

  assign alu_op = ALUOP_W'(op_c);
  assign legal  = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ready handshakes, traps on illegal instructions and memory timeouts,
// and counts retired instructions.
// Ports: clk, rst (async active-high); bus (mc_ctrl_if.master) carries run,
// IR fields, branch result, memory handshakes, datapath selects and status.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned WAIT_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_e             state_q, state_d;
  trap_cause_e        cause_q, cause_d;
  logic               trap_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;

  instr_class_e       cls;
  logic               legal;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src1, alu_src2, imm_ext;

  logic               imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write;
  logic [1:0]         npc_from, reg_dst, mem_to_reg;
  logic               waiting_c, timeout_c;

  mc_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .cls      (cls),
    .alu_op   (alu_op),
    .alu_src1 (alu_src1),
    .alu_src2 (alu_src2),
    .imm_ext  (imm_ext),
    .legal    (legal)
  );

  // Stalled on a memory handshake; counter hits its last value -> trap unless ready
  assign waiting_c = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                     ((state_q == ST_MEM)   && !bus.dmem_ready);
  assign timeout_c = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(WAIT_LAST));

  // State, wait counter, sticky trap and retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (waiting_c && (MEM_TIMEOUT != 0))
        wait_q <= wait_q + WAIT_W'(1);
      if ((state_d == ST_TRAP) && (state_q != ST_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
      if (pc_write)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next state and per-state control outputs
  always_comb begin
    state_d    = state_q;
    cause_d    = CAUSE_NONE;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    npc_from   = NPC_PC4;
    reg_dst    = SEL_REGDST_RT;
    mem_to_reg = SEL_WB_ALUOUT;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM;
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (cls == CLS_JUMP) begin
          pc_write = 1'b1;
          npc_from = NPC_JMP;
          state_d  = ST_FETCH;
        end else if (cls == CLS_JAL) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          npc_from = bus.branch_taken ? NPC_BRANCH : NPC_PC4;
          state_d  = ST_FETCH;
        end else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (bus.dmem_ready) begin
          if (cls == CLS_STORE) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
        case (cls)
          CLS_ALU_R: reg_dst = SEL_REGDST_RD;
          CLS_LOAD:  mem_to_reg = SEL_WB_DM;
          CLS_JAL: begin
            reg_dst    = SEL_REGDST_RA;
            mem_to_reg = SEL_WB_PC4;
            npc_from   = NPC_JMP;
          end
          default: ;
        endcase
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = ir_write;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.pc_write   = pc_write;
  assign bus.npc_from   = npc_from;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src1   = alu_src1;
  assign bus.alu_src2   = alu_src2;
  assign bus.alu_op     = alu_op;
  assign bus.imm_ext    = imm_ext;
  assign bus.state_o    = state_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule
